// File: rtl/exe_div_sequencer.sv
// ----------------------------------------------------------------------------
// exe_div_sequencer
//   Multi-cycle divider for MIPS DIV/DIVU in the EXE stage. It runs a
//   DIV_WIDTH-iteration restoring divide on operand magnitudes, applies the
//   sign fix-up, and then holds quotient (LO) and remainder (HI) until the
//   downstream stage acknowledges them.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   EXE_DivStart    request valid
//   EXE_DivSigned   1 = DIV (signed), 0 = DIVU
//   EXE_Dividend    rs operand, captured on accept
//   EXE_Divisor     rt operand, captured on accept
//   EXE_Flush       abort whatever is in flight; return to IDLE
//   EXE_DivAck      downstream consumes the result this cycle
//   EXE_DivBusy     stall request to pipeline control (combinational)
//   EXE_DivDone     result valid
//   EXE_DivQuot     quotient, to LO
//   EXE_DivRem      remainder, to HI
//
// Handshake
//   Request side: a request is accepted in any cycle where EXE_DivStart=1,
//   EXE_Flush=0 and the unit is in IDLE, or in DONE with EXE_DivAck=1.
//   EXE_DivBusy rises in that same cycle. Result side: EXE_DivDone is the
//   valid and EXE_DivAck the ready; the result is held stable while
//   EXE_DivDone=1 and EXE_DivAck=0, and is consumed on the cycle both are 1.
// ----------------------------------------------------------------------------
module exe_div_sequencer #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EXE_DivStart,
  input  logic                 EXE_DivSigned,
  input  logic [DIV_WIDTH-1:0] EXE_Dividend,
  input  logic [DIV_WIDTH-1:0] EXE_Divisor,
  input  logic                 EXE_Flush,
  input  logic                 EXE_DivAck,
  output logic                 EXE_DivBusy,
  output logic                 EXE_DivDone,
  output logic [DIV_WIDTH-1:0] EXE_DivQuot,
  output logic [DIV_WIDTH-1:0] EXE_DivRem
);

  localparam int CW = $clog2(DIV_WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        counter;
  // Dividend magnitude shifts out of the top while quotient bits shift in
  // at the bottom, so one register holds both.
  logic [DIV_WIDTH-1:0] quo_dvd;
  logic [DIV_WIDTH:0]   prem;
  logic [DIV_WIDTH-1:0] dsr_mag;
  logic                 signed_op;
  logic                 dvd_sign;
  logic                 dsr_sign;
  logic                 no_fix;

  logic                 accept;
  logic                 in_dvd_neg;
  logic                 in_dsr_neg;
  logic [DIV_WIDTH-1:0] in_dvd_abs;
  logic [DIV_WIDTH-1:0] in_dsr_abs;
  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH:0]   trial;
  logic [DIV_WIDTH-1:0] fix_q;
  logic [DIV_WIDTH-1:0] fix_r;

  always_comb begin
    accept = EXE_DivStart && !EXE_Flush &&
             ((state == S_IDLE) || ((state == S_DONE) && EXE_DivAck));
    EXE_DivBusy = (state == S_CALC) || (state == S_FIX) || accept;

    in_dvd_neg = EXE_DivSigned && EXE_Dividend[DIV_WIDTH-1];
    in_dsr_neg = EXE_DivSigned && EXE_Divisor[DIV_WIDTH-1];
    in_dvd_abs = in_dvd_neg ? -EXE_Dividend : EXE_Dividend;
    in_dsr_abs = in_dsr_neg ? -EXE_Divisor  : EXE_Divisor;

    // Restoring step: the sign bit of the (DIV_WIDTH+1)-bit trial result
    // says whether the divisor fit.
    shifted = {prem[DIV_WIDTH-1:0], quo_dvd[DIV_WIDTH-1]};
    trial   = shifted - {1'b0, dsr_mag};

    fix_q = (signed_op && (dvd_sign ^ dsr_sign)) ? -quo_dvd : quo_dvd;
    fix_r = (signed_op && dvd_sign) ? -prem[DIV_WIDTH-1:0] : prem[DIV_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      counter     <= '0;
      quo_dvd     <= '0;
      prem        <= '0;
      dsr_mag     <= '0;
      signed_op   <= 1'b0;
      dvd_sign    <= 1'b0;
      dsr_sign    <= 1'b0;
      no_fix      <= 1'b0;
      EXE_DivDone <= 1'b0;
      EXE_DivQuot <= '0;
      EXE_DivRem  <= '0;
    end else if (EXE_Flush) begin
      // Result registers keep their last values: HI/LO is never written
      // without a completed divide.
      state       <= S_IDLE;
      counter     <= '0;
      EXE_DivDone <= 1'b0;
    end else if (accept) begin
      signed_op   <= EXE_DivSigned;
      dvd_sign    <= in_dvd_neg;
      dsr_sign    <= in_dsr_neg;
      dsr_mag     <= in_dsr_abs;
      EXE_DivDone <= 1'b0;
      if (EXE_Divisor == '0) begin
        // Divide by zero skips the iterations: all-ones quotient and the
        // raw dividend as remainder, with no sign fix-up.
        no_fix  <= 1'b1;
        quo_dvd <= '1;
        prem    <= {1'b0, EXE_Dividend};
        counter <= '0;
        state   <= S_FIX;
      end else begin
        no_fix  <= 1'b0;
        quo_dvd <= in_dvd_abs;
        prem    <= '0;
        counter <= CW'(DIV_WIDTH);
        state   <= S_CALC;
      end
    end else begin
      case (state)
        S_CALC: begin
          if (!trial[DIV_WIDTH]) begin
            prem    <= trial;
            quo_dvd <= {quo_dvd[DIV_WIDTH-2:0], 1'b1};
          end else begin
            prem    <= shifted;
            quo_dvd <= {quo_dvd[DIV_WIDTH-2:0], 1'b0};
          end
          counter <= counter - CW'(1);
          if (counter == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          EXE_DivQuot <= no_fix ? quo_dvd : fix_q;
          EXE_DivRem  <= no_fix ? prem[DIV_WIDTH-1:0] : fix_r;
          EXE_DivDone <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          if (EXE_DivAck) begin
            EXE_DivDone <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
